// File: rtl/score_bcd_if.sv
// Score/display bundle between the game controller and the BCD converter.
// The controller (master) drives the binary score; the converter (slave) returns digits and status.
interface score_bcd_if #(
    parameter int W_IN = 10
);
    logic [W_IN-1:0] score;
    logic [3:0]      dig0;
    logic [3:0]      dig1;
    logic [3:0]      dig2;
    logic            ovf;
    logic            busy;
    logic            updated;

    modport master (
        output score,
        input  dig0, dig1, dig2, ovf, busy, updated
    );

    modport slave (
        input  score,
        output dig0, dig1, dig2, ovf, busy, updated
    );
endinterface

// File: rtl/score_bcd.sv
// Sequential double-dabble binary-to-BCD converter for the three-digit score display.
// Reconverts only when the score changes and saturates at SAT so every digit stays decimal.
module score_bcd #(
    parameter int W_IN = 10,
    parameter int SAT  = 999
) (
    input  logic        clk,
    input  logic        reset,
    score_bcd_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } state_t;

    localparam logic [W_IN-1:0] SAT_V = W_IN'(SAT);

    state_t          state;
    logic [W_IN-1:0] last_score;
    logic [W_IN-1:0] shreg;
    logic [11:0]     bcd;
    logic [10:0]     bcd_adj;
    logic [3:0]      cnt;
    logic            ovf_pend;

    // The hundreds nibble never needs an add-3: a final digit of at most 9 means it is at most 4 before any shift.
    always_comb begin
        bcd_adj = bcd[10:0];
        if (bcd[3:0] >= 4'd5) begin
            bcd_adj[3:0] = bcd[3:0] + 4'd3;
        end
        if (bcd[7:4] >= 4'd5) begin
            bcd_adj[7:4] = bcd[7:4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_score  <= '0;
            shreg       <= '0;
            bcd         <= '0;
            cnt         <= '0;
            ovf_pend    <= 1'b0;
            bus.dig0    <= '0;
            bus.dig1    <= '0;
            bus.dig2    <= '0;
            bus.ovf     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.updated <= 1'b0;
        end else begin
            bus.updated <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.score != last_score) begin
                        last_score <= bus.score;
                        shreg      <= (bus.score > SAT_V) ? SAT_V : bus.score;
                        ovf_pend   <= (bus.score > SAT_V);
                        bcd        <= '0;
                        cnt        <= '0;
                        bus.busy   <= 1'b1;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    {bcd, shreg} <= {bcd_adj, shreg, 1'b0};
                    cnt          <= cnt + 4'd1;
                    if (cnt == 4'(W_IN - 1)) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    // Digits change only here, so the display never shows a partial conversion.
                    bus.dig0    <= bcd[3:0];
                    bus.dig1    <= bcd[7:4];
                    bus.dig2    <= bcd[11:8];
                    bus.ovf     <= ovf_pend;
                    bus.updated <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd.sv
// Self-checking bench for score_bcd: directed scenarios plus randomized scores
// compared against a decimal-arithmetic reference model.
module tb_score_bcd;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    score_bcd_if #(.W_IN(10)) bus ();

    score_bcd #(.W_IN(10), .SAT(999)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Expected {ovf, hundreds, tens, ones} for a binary score.
    function automatic logic [12:0] ref_model(input int v);
        int s;
        s = (v > 999) ? 999 : v;
        return {logic'(v > 999), 4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.ovf, bus.dig2, bus.dig1, bus.dig0};
    endfunction

    task automatic apply_score(input int v);
        @(negedge clk);
        bus.score = 10'(v);
    endtask

    // Counts edges until an updated pulse is seen, bounded by budget.
    task automatic wait_update(input int budget, output int cycles, output int busy_cnt, output bit seen);
        cycles   = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.busy) busy_cnt++;
            if (bus.updated) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int busy_hits;
        int upd_hits;
        reset     = 1'b1;
        bus.score = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (observed() !== 13'h0) $display("[TB] FAIL reset_digits: got %h expected %h", observed(), 13'h0);
        else passed++;
        total++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        else passed++;
        total++;
        if (bus.updated !== 1'b0) $display("[TB] FAIL reset_updated: got %b expected 0", bus.updated);
        else passed++;
        @(negedge clk);
        reset     = 1'b0;
        busy_hits = 0;
        upd_hits  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_hits++;
            if (bus.updated) upd_hits++;
        end
        total++;
        if (busy_hits != 0) $display("[TB] FAIL zero_busy: got %0d busy cycles expected 0", busy_hits);
        else passed++;
        total++;
        if (upd_hits != 0) $display("[TB] FAIL zero_updated: got %0d pulses expected 0", upd_hits);
        else passed++;
        total++;
        if (observed() !== 13'h0) $display("[TB] FAIL zero_digits: got %h expected %h", observed(), 13'h0);
        else passed++;
    endtask

    task automatic test_single();
        int cycles, busy_cnt;
        bit seen;
        apply_score(123);
        wait_update(20, cycles, busy_cnt, seen);
        total++;
        if (!seen || cycles != 12) $display("[TB] FAIL single_latency: got seen=%0b edges=%0d expected edges=12", seen, cycles);
        else passed++;
        total++;
        if (busy_cnt != 11) $display("[TB] FAIL single_busy: got %0d busy cycles expected 11", busy_cnt);
        else passed++;
        total++;
        if (observed() !== ref_model(123)) $display("[TB] FAIL single_value: got %h expected %h", observed(), ref_model(123));
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (bus.updated !== 1'b0) $display("[TB] FAIL single_pulse_width: got updated=%b expected 0", bus.updated);
        else passed++;
    endtask

    task automatic test_saturation();
        int vals[4] = '{999, 1000, 1023, 7};
        int cycles, busy_cnt;
        bit seen;
        foreach (vals[i]) begin
            apply_score(vals[i]);
            wait_update(20, cycles, busy_cnt, seen);
            total++;
            if (!seen || cycles != 12 || observed() !== ref_model(vals[i]))
                $display("[TB] FAIL saturation v=%0d: got %h edges=%0d expected %h edges=12",
                         vals[i], observed(), cycles, ref_model(vals[i]));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int cycles, busy_cnt;
        bit seen;
        apply_score(45);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.score = 10'd46;
        wait_update(20, cycles, busy_cnt, seen);
        total++;
        if (!seen || cycles != 10 || observed() !== ref_model(45))
            $display("[TB] FAIL b2b_first: got %h edges=%0d expected %h edges=10", observed(), cycles, ref_model(45));
        else passed++;
        wait_update(20, cycles, busy_cnt, seen);
        total++;
        if (!seen || cycles != 12 || observed() !== ref_model(46))
            $display("[TB] FAIL b2b_second: got %h edges=%0d expected %h edges=12", observed(), cycles, ref_model(46));
        else passed++;
    endtask

    task automatic test_bounce();
        int cycles, busy_cnt;
        bit seen;
        apply_score(300);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.score = 10'd301;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.score = 10'd300;
        wait_update(20, cycles, busy_cnt, seen);
        total++;
        if (!seen || observed() !== ref_model(300))
            $display("[TB] FAIL bounce_value: got %h seen=%0b expected %h", observed(), seen, ref_model(300));
        else passed++;
        wait_update(15, cycles, busy_cnt, seen);
        total++;
        if (seen || busy_cnt != 0)
            $display("[TB] FAIL bounce_extra: got seen=%0b busy=%0d expected seen=0 busy=0", seen, busy_cnt);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int cycles, busy_cnt;
        bit seen;
        apply_score(789);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (observed() !== 13'h0 || bus.busy !== 1'b0 || bus.updated !== 1'b0)
            $display("[TB] FAIL abort_state: got digits=%h busy=%b updated=%b expected 0/0/0",
                     observed(), bus.busy, bus.updated);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        wait_update(20, cycles, busy_cnt, seen);
        total++;
        if (!seen || cycles != 12 || observed() !== ref_model(789))
            $display("[TB] FAIL abort_reconvert: got %h edges=%0d expected %h edges=12", observed(), cycles, ref_model(789));
        else passed++;
    endtask

    task automatic test_sweep();
        int cycles, busy_cnt;
        bit seen;
        for (int v = 0; v < 1024; v++) begin
            apply_score(v);
            wait_update(20, cycles, busy_cnt, seen);
            total++;
            if (!seen || cycles != 12 || observed() !== ref_model(v))
                $display("[TB] FAIL sweep v=%0d: got %h edges=%0d expected %h edges=12", v, observed(), cycles, ref_model(v));
            else passed++;
        end
    endtask

    // Random first score, then a random later score injected k edges into its conversion.
    task automatic test_random();
        int cycles, busy_cnt, k, v1, v2, prev;
        bit seen;
        prev = 1023;
        repeat (150) begin
            v1 = int'($urandom_range(0, 1023));
            if (v1 == prev) v1 = v1 ^ 1;
            v2 = int'($urandom_range(0, 1023));
            if (v2 == v1) v2 = v1 ^ 2;
            k = int'($urandom_range(1, 10));
            apply_score(v1);
            repeat (k) @(posedge clk);
            @(negedge clk);
            bus.score = 10'(v2);
            wait_update(20, cycles, busy_cnt, seen);
            total++;
            if (!seen || cycles != 12 - k || observed() !== ref_model(v1))
                $display("[TB] FAIL random_first v=%0d k=%0d: got %h edges=%0d expected %h edges=%0d",
                         v1, k, observed(), cycles, ref_model(v1), 12 - k);
            else passed++;
            wait_update(20, cycles, busy_cnt, seen);
            total++;
            if (!seen || cycles != 12 || observed() !== ref_model(v2))
                $display("[TB] FAIL random_second v=%0d: got %h edges=%0d expected %h edges=12",
                         v2, observed(), cycles, ref_model(v2));
            else passed++;
            prev = v2;
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.score = '0;
        test_reset();
        test_single();
        test_saturation();
        test_back_to_back();
        test_bounce();
        test_reset_abort();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit with %0d/%0d checks done", passed, total);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
